// File: rtl/ram_axi_request.sv
// CPU-side external RAM request initiator: byte read/write strobes become AXI4-Lite
// master transactions. A read is held behind an outstanding write to keep RAW ordering.
module ram_axi_request #(
  parameter int unsigned               ADDR_WIDTH     = 21,
  parameter int unsigned               AXI_ADDR_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0000_0000
) (
  input  logic                      clk_peripheral_n,
  input  logic                      reset_n,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic [7:0]                data_i,
  input  logic                      rd_req_i,
  input  logic                      wr_req_i,
  output logic [7:0]                data_o,
  output logic                      aw_ready,
  output logic                      ar_ready,
  output logic [1:0]                err_o,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [31:0]               m_axi_wdata,
  output logic [3:0]                m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [31:0]               m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  typedef enum logic [1:0] {WIdle, WReq, WResp} w_state_e;
  typedef enum logic [1:0] {RIdle, RHold, RAddr, RData} r_state_e;

  w_state_e                  w_state_q, w_state_d;
  r_state_e                  r_state_q, r_state_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [3:0]                wstrb_q, wstrb_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      bready_q, bready_d;
  logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [1:0]                r_lane_q, r_lane_d;
  logic                      arvalid_q, arvalid_d;
  logic                      rready_q, rready_d;
  logic [7:0]                data_q, data_d;
  logic [1:0]                err_q, err_d;

  logic [AXI_ADDR_WIDTH-1:0] full_addr;
  logic [AXI_ADDR_WIDTH-1:0] word_addr;
  logic                      wr_ovr, rd_ovr, w_resp_err, r_resp_err;

  assign full_addr = BASE_ADDR + AXI_ADDR_WIDTH'(addr_i);
  assign word_addr = full_addr & ~(AXI_ADDR_WIDTH'(3));

  // Write channel
  always_comb begin
    w_state_d  = w_state_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    w_resp_err = 1'b0;
    wr_ovr     = wr_req_i && (w_state_q != WIdle);
    unique case (w_state_q)
      WIdle: begin
        if (wr_req_i) begin
          awaddr_d  = word_addr;
          wdata_d   = {4{data_i}};
          wstrb_d   = 4'(4'b0001 << addr_i[1:0]);
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          w_state_d = WReq;
        end
      end
      WReq: begin
        // AW and W accepts are tracked independently and may arrive in any order.
        if (m_axi_awready) awvalid_d = 1'b0;
        if (m_axi_wready)  wvalid_d  = 1'b0;
        if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
          bready_d  = 1'b1;
          w_state_d = WResp;
        end
      end
      WResp: begin
        if (m_axi_bvalid) begin
          bready_d   = 1'b0;
          w_resp_err = (m_axi_bresp != 2'b00);
          w_state_d  = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  // Read channel
  always_comb begin
    r_state_d  = r_state_q;
    araddr_d   = araddr_q;
    r_lane_d   = r_lane_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    data_d     = data_q;
    r_resp_err = 1'b0;
    rd_ovr     = rd_req_i && (r_state_q != RIdle);
    unique case (r_state_q)
      RIdle: begin
        if (rd_req_i) begin
          araddr_d = word_addr;
          r_lane_d = addr_i[1:0];
          if ((w_state_q != WIdle) || wr_req_i) begin
            r_state_d = RHold;
          end else begin
            arvalid_d = 1'b1;
            r_state_d = RAddr;
          end
        end
      end
      RHold: begin
        if (w_state_q == WIdle) begin
          arvalid_d = 1'b1;
          r_state_d = RAddr;
        end
      end
      RAddr: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          r_state_d = RData;
        end
      end
      RData: begin
        if (m_axi_rvalid) begin
          data_d     = m_axi_rdata[8*r_lane_q +: 8];
          r_resp_err = (m_axi_rresp != 2'b00);
          rready_d   = 1'b0;
          r_state_d  = RIdle;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_comb begin
    err_d = err_q | {wr_ovr | rd_ovr, w_resp_err | r_resp_err};
  end

  always_ff @(posedge clk_peripheral_n) begin
    if (!reset_n) begin
      w_state_q <= WIdle;
      r_state_q <= RIdle;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      araddr_q  <= '0;
      r_lane_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      data_q    <= '0;
      err_q     <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      araddr_q  <= araddr_d;
      r_lane_q  <= r_lane_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end
  end

  assign aw_ready      = (w_state_q == WIdle);
  assign ar_ready      = (r_state_q == RIdle);
  assign data_o        = data_q;
  assign err_o         = err_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_ram_axi_request.sv
// Bench for ram_axi_request: a delay-configurable AXI4-Lite slave with a word memory,
// plus scenario tasks; expected read bytes go through a scoreboard queue.
module tb_ram_axi_request;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [20:0] addr_i = '0;
  logic [7:0]  data_i = '0;
  logic        rd_req_i = 1'b0;
  logic        wr_req_i = 1'b0;
  logic [7:0]  data_o;
  logic        aw_ready, ar_ready;
  logic [1:0]  err_o;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awready = 1'b0;
  logic        m_axi_wready = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_arready = 1'b0;
  logic [31:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = 2'b00;
  logic        m_axi_rvalid = 1'b0;

  always #5 clk = ~clk;

  ram_axi_request dut (
    .clk_peripheral_n(clk),
    .reset_n         (reset_n),
    .addr_i          (addr_i),
    .data_i          (data_i),
    .rd_req_i        (rd_req_i),
    .wr_req_i        (wr_req_i),
    .data_o          (data_o),
    .aw_ready        (aw_ready),
    .ar_ready        (ar_ready),
    .err_o           (err_o),
    .m_axi_awaddr    (m_axi_awaddr),
    .m_axi_awvalid   (m_axi_awvalid),
    .m_axi_awready   (m_axi_awready),
    .m_axi_wdata     (m_axi_wdata),
    .m_axi_wstrb     (m_axi_wstrb),
    .m_axi_wvalid    (m_axi_wvalid),
    .m_axi_wready    (m_axi_wready),
    .m_axi_bresp     (m_axi_bresp),
    .m_axi_bvalid    (m_axi_bvalid),
    .m_axi_bready    (m_axi_bready),
    .m_axi_araddr    (m_axi_araddr),
    .m_axi_arvalid   (m_axi_arvalid),
    .m_axi_arready   (m_axi_arready),
    .m_axi_rdata     (m_axi_rdata),
    .m_axi_rresp     (m_axi_rresp),
    .m_axi_rvalid    (m_axi_rvalid),
    .m_axi_rready    (m_axi_rready)
  );

  int total = 0;
  int bad = 0;

  // Slave configuration and bookkeeping
  int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int          aw_count = 0, b_count = 0, r_count = 0;
  logic        aw_done = 1'b0, w_done = 1'b0, ar_done = 1'b0;
  logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
  logic [3:0]  s_wstrb = '0;
  logic [31:0] mem [16];
  logic [7:0]  exp_q [$];

  // Slave changes its outputs on the falling edge; the DUT samples them on the rising edge.
  initial begin : axi_slave
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[1] = 32'h4433_2211;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
        aw_done = 1'b0; w_done = 1'b0; ar_done = 1'b0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      end else begin
        if (m_axi_awvalid && aw_cnt >= aw_delay) begin
          m_axi_awready = 1'b1; s_awaddr = m_axi_awaddr; aw_done = 1'b1; aw_count++; aw_cnt = 0;
        end else begin
          m_axi_awready = 1'b0; aw_cnt = m_axi_awvalid ? aw_cnt + 1 : 0;
        end
        if (m_axi_wvalid && w_cnt >= w_delay) begin
          m_axi_wready = 1'b1; s_wdata = m_axi_wdata; s_wstrb = m_axi_wstrb; w_done = 1'b1;
          w_cnt = 0;
        end else begin
          m_axi_wready = 1'b0; w_cnt = m_axi_wvalid ? w_cnt + 1 : 0;
        end
        if (m_axi_bvalid) begin
          m_axi_bvalid = 1'b0;
        end else if (m_axi_bready && aw_done && w_done && b_cnt >= b_delay) begin
          for (int k = 0; k < 4; k++)
            if (s_wstrb[k]) mem[s_awaddr[5:2]][8*k +: 8] = s_wdata[8*k +: 8];
          m_axi_bvalid = 1'b1; m_axi_bresp = bresp_cfg;
          aw_done = 1'b0; w_done = 1'b0; b_count++; b_cnt = 0;
        end else begin
          b_cnt = (m_axi_bready && aw_done && w_done) ? b_cnt + 1 : 0;
        end
        if (m_axi_arvalid && ar_cnt >= ar_delay) begin
          m_axi_arready = 1'b1; s_araddr = m_axi_araddr; ar_done = 1'b1; ar_cnt = 0;
        end else begin
          m_axi_arready = 1'b0; ar_cnt = m_axi_arvalid ? ar_cnt + 1 : 0;
        end
        if (m_axi_rvalid) begin
          m_axi_rvalid = 1'b0;
        end else if (m_axi_rready && ar_done && r_cnt >= r_delay) begin
          m_axi_rvalid = 1'b1; m_axi_rdata = mem[s_araddr[5:2]]; m_axi_rresp = rresp_cfg;
          ar_done = 1'b0; r_count++; r_cnt = 0;
        end else begin
          r_cnt = (m_axi_rready && ar_done) ? r_cnt + 1 : 0;
        end
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0; rd_req_i = 1'b0; wr_req_i = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({aw_ready, ar_ready} !== 2'b11) begin
      bad++; $display("FAIL reset_idle: got %b want 11", {aw_ready, ar_ready});
    end
    total++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 5'b0) begin
      bad++; $display("FAIL reset_handshake: got %b want 00000",
                      {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready});
    end
    total++;
    if (data_o !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data_o); end
    total++;
    if (err_o !== 2'b00) begin bad++; $display("FAIL reset_err: got %b want 00", err_o); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    int lat = -1;
    aw_delay = 0; w_delay = 0; b_delay = 2; bresp_cfg = 2'b00;
    addr_i = 21'h00_0003; data_i = 8'hA5; wr_req_i = 1'b1;
    @(negedge clk);
    wr_req_i = 1'b0;
    total++;
    if (m_axi_awaddr !== 32'h0) begin
      bad++; $display("FAIL wr_awaddr: got %h want 00000000", m_axi_awaddr);
    end
    total++;
    if (m_axi_wstrb !== 4'b1000) begin bad++; $display("FAIL wr_wstrb: got %b want 1000", m_axi_wstrb); end
    total++;
    if (m_axi_wdata !== 32'hA5A5_A5A5) begin
      bad++; $display("FAIL wr_wdata: got %h want a5a5a5a5", m_axi_wdata);
    end
    total++;
    if ({aw_ready, m_axi_awvalid, m_axi_wvalid} !== 3'b011) begin
      bad++; $display("FAIL wr_issue: got %b want 011", {aw_ready, m_axi_awvalid, m_axi_wvalid});
    end
    for (int i = 0; i < 50; i++) begin
      if (aw_ready) begin lat = i; break; end
      @(negedge clk);
    end
    total++;
    if (lat !== 4) begin bad++; $display("FAIL wr_latency: got %0d want 4", lat); end
    total++;
    if (err_o !== 2'b00) begin bad++; $display("FAIL wr_err: got %b want 00", err_o); end
    total++;
    if (mem[0] !== 32'hA500_0000) begin bad++; $display("FAIL wr_mem: got %h want a5000000", mem[0]); end
  endtask

  task automatic test_read();
    int ar_hi = 0;
    logic done = 1'b0;
    logic [7:0] exp_b;
    ar_delay = 3; r_delay = 0; rresp_cfg = 2'b00;
    addr_i = 21'h00_0006; rd_req_i = 1'b1; exp_q.push_back(8'h33);
    @(negedge clk);
    rd_req_i = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ar_ready) begin done = 1'b1; break; end
      if (m_axi_arvalid) begin
        ar_hi++; total++;
        if (m_axi_araddr !== 32'h4) begin
          bad++; $display("FAIL rd_araddr: got %h want 00000004", m_axi_araddr);
        end
      end
      @(negedge clk);
    end
    total++;
    if (!done) begin bad++; $display("FAIL rd_timeout: got ar_ready=0 want 1"); end
    total++;
    if (ar_hi !== 4) begin bad++; $display("FAIL rd_arvalid_hold: got %0d want 4", ar_hi); end
    exp_b = exp_q.pop_front();
    total++;
    if (data_o !== exp_b) begin bad++; $display("FAIL rd_data: got %h want %h", data_o, exp_b); end
  endtask

  task automatic test_w_before_aw();
    int aw_hi = 0, w_hi = 0, b0;
    logic done = 1'b0;
    aw_delay = 4; w_delay = 0; b_delay = 0;
    b0 = b_count;
    addr_i = 21'h00_0010; data_i = 8'h7E; wr_req_i = 1'b1;
    @(negedge clk);
    wr_req_i = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (aw_ready) begin done = 1'b1; break; end
      if (m_axi_awvalid) aw_hi++;
      if (m_axi_wvalid) w_hi++;
      if (m_axi_awvalid || m_axi_wvalid) begin
        total++;
        if (m_axi_bready !== 1'b0) begin bad++; $display("FAIL early_bready: got 1 want 0"); end
      end
      @(negedge clk);
    end
    total++;
    if (!done) begin bad++; $display("FAIL wa_timeout: got aw_ready=0 want 1"); end
    total++;
    if (w_hi !== 1) begin bad++; $display("FAIL wa_wvalid_cycles: got %0d want 1", w_hi); end
    total++;
    if (aw_hi !== 5) begin bad++; $display("FAIL wa_awvalid_cycles: got %0d want 5", aw_hi); end
    total++;
    if (b_count - b0 !== 1) begin bad++; $display("FAIL wa_bresp_count: got %0d want 1", b_count - b0); end
    total++;
    if (mem[4] !== 32'h0000_007E) begin bad++; $display("FAIL wa_mem: got %h want 0000007e", mem[4]); end
  endtask

  task automatic test_raw();
    int b0, ar_hi = 0;
    logic done = 1'b0;
    logic [7:0] exp_b;
    aw_delay = 1; w_delay = 1; b_delay = 1; ar_delay = 0; r_delay = 0;
    b0 = b_count;
    addr_i = 21'h00_0009; data_i = 8'h5C; wr_req_i = 1'b1; rd_req_i = 1'b1;
    exp_q.push_back(8'h5C);
    @(negedge clk);
    wr_req_i = 1'b0; rd_req_i = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (ar_ready) begin done = 1'b1; break; end
      if (m_axi_arvalid) begin
        ar_hi++; total++;
        if (b_count == b0) begin bad++; $display("FAIL raw_order: got arvalid=1 before bresp want 0"); end
      end
      @(negedge clk);
    end
    total++;
    if (!done) begin bad++; $display("FAIL raw_timeout: got ar_ready=0 want 1"); end
    total++;
    if (ar_hi !== 1) begin bad++; $display("FAIL raw_arvalid_cycles: got %0d want 1", ar_hi); end
    exp_b = exp_q.pop_front();
    total++;
    if (data_o !== exp_b) begin bad++; $display("FAIL raw_data: got %h want %h", data_o, exp_b); end
  endtask

  task automatic test_overrun();
    int a0;
    logic done = 1'b0;
    aw_delay = 0; w_delay = 0; b_delay = 3; bresp_cfg = 2'b10;
    a0 = aw_count;
    addr_i = 21'h00_0020; data_i = 8'h11; wr_req_i = 1'b1;
    @(negedge clk);
    wr_req_i = 1'b0;
    @(negedge clk);
    addr_i = 21'h00_0024; data_i = 8'h22; wr_req_i = 1'b1;
    @(negedge clk);
    wr_req_i = 1'b0;
    total++;
    if (err_o !== 2'b10) begin bad++; $display("FAIL ovr_err: got %b want 10", err_o); end
    for (int i = 0; i < 50; i++) begin
      if (aw_ready) begin done = 1'b1; break; end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    total++;
    if (!done) begin bad++; $display("FAIL ovr_timeout: got aw_ready=0 want 1"); end
    total++;
    if (err_o !== 2'b11) begin bad++; $display("FAIL slverr_err: got %b want 11", err_o); end
    total++;
    if (aw_count - a0 !== 1) begin bad++; $display("FAIL ovr_aw_count: got %0d want 1", aw_count - a0); end
    total++;
    if (mem[9] !== 32'h0) begin bad++; $display("FAIL ovr_dropped_write: got %h want 00000000", mem[9]); end
    bresp_cfg = 2'b00;
  endtask

  task automatic test_reset_in_read();
    logic done = 1'b0;
    logic [7:0] exp_b;
    ar_delay = 0; r_delay = 6;
    addr_i = 21'h00_0006; rd_req_i = 1'b1;
    @(negedge clk);
    rd_req_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_axi_rready) begin done = 1'b1; break; end
      @(negedge clk);
    end
    total++;
    if (!done) begin bad++; $display("FAIL rst_rdata_timeout: got rready=0 want 1"); end
    reset_n = 1'b0;
    @(negedge clk);
    total++;
    if ({m_axi_arvalid, m_axi_rready, ar_ready} !== 3'b001) begin
      bad++; $display("FAIL rst_rd_state: got %b want 001", {m_axi_arvalid, m_axi_rready, ar_ready});
    end
    total++;
    if (data_o !== 8'h00) begin bad++; $display("FAIL rst_rd_data: got %h want 00", data_o); end
    total++;
    if (err_o !== 2'b00) begin bad++; $display("FAIL rst_rd_err: got %b want 00", err_o); end
    @(negedge clk);
    reset_n = 1'b1; r_delay = 0;
    @(negedge clk);
    done = 1'b0;
    addr_i = 21'h00_0004; rd_req_i = 1'b1; exp_q.push_back(8'h11);
    @(negedge clk);
    rd_req_i = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ar_ready) begin done = 1'b1; break; end
      @(negedge clk);
    end
    total++;
    if (!done) begin bad++; $display("FAIL rst_fresh_timeout: got ar_ready=0 want 1"); end
    exp_b = exp_q.pop_front();
    total++;
    if (data_o !== exp_b) begin bad++; $display("FAIL rst_fresh_data: got %h want %h", data_o, exp_b); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_w_before_aw();
    test_raw();
    test_overrun();
    test_reset_in_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
